// File: rtl/dist_smoother.sv
// Purpose : moving-average filter over a 2^LOG2N-sample circular window of distance samples.
// Latency : one register stage; the accepting edge updates dist_out and pulses dist_out_valid.
// Backpressure: none, every strobe is taken; optional DIST_ZERO_REJECT_EN drops zero samples.
module dist_smoother #(
  parameter int DW    = 6,
  parameter int LOG2N = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dist_in,
  input  logic          dist_valid,
  input  logic          clear,
  output logic [DW-1:0] dist_out,
  output logic          dist_out_valid,
  output logic          win_full
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = DW + LOG2N;             // sum cannot exceed N*(2^DW-1) + N/2
  localparam int CW = LOG2N + 1;
  localparam int PW = (LOG2N > 0) ? LOG2N : 1; // keep the pointer at least one bit wide

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_inc;
  logic [SW-1:0]  sum;
  logic [SW-1:0]  sum_next;
  logic [DW-1:0]  old;
  logic [DW-1:0]  avg;
  logic           accept;
  logic           publish;
  logic [DW-1:0]  win_buf [N];

`ifdef DIST_ZERO_REJECT_EN
  // A zero is the calculator's no-match code; such strobes leave the window untouched.
  assign accept = dist_valid && !clear && (dist_in != '0);
`else
  assign accept = dist_valid && !clear;
`endif

  // Only once the window is full does the incoming sample displace an older one.
  assign old       = (state == RUN) ? win_buf[wr_ptr] : '0;
  assign sum_next  = sum + SW'(dist_in) - SW'(old);
  assign count_inc = count + CW'(1);
  // Round half up, then divide by the window depth.
  assign avg       = DW'((sum_next + SW'(N / 2)) >> LOG2N);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Next state and the decision to publish a new average on this edge.
  always_comb begin
    state_next = state;
    publish    = 1'b0;
    if (clear) begin
      state_next = EMPTY;
    end else if (accept) begin
      case (state)
        EMPTY, FILL: begin
          if (count_inc == CW'(N)) begin
            state_next = RUN;
            publish    = 1'b1;
          end else begin
            state_next = FILL;
          end
        end
        RUN:     publish = 1'b1;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Window bookkeeping: pointer, fill count and running sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
      sum    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      count  <= '0;
      sum    <= '0;
    end else if (accept) begin
      wr_ptr <= (wr_ptr == PW'(N - 1)) ? '0 : wr_ptr + PW'(1);
      count  <= (count == CW'(N)) ? count : count_inc;
      sum    <= sum_next;
    end
  end

  // Output registers; dist_out holds across clear so the display does not blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_out       <= '0;
      dist_out_valid <= 1'b0;
      win_full       <= 1'b0;
    end else begin
      dist_out_valid <= publish;
      win_full       <= (state_next == RUN);
      if (publish) dist_out <= avg;
    end
  end

  // Sample storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) win_buf[wr_ptr] <= dist_in;
  end

endmodule

// File: tb/tb_dist_smoother.sv
module tb_dist_smoother;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] dist_in;
  logic       dist_valid;
  logic       clear;
  logic [5:0] dist_out;
  logic       dist_out_valid;
  logic       win_full;

  int checks = 0;
  int errors = 0;

  int e2 [8] = '{23, 25, 28, 30, 33, 35, 38, 40};
  int e4 [5] = '{36, 32, 28, 24, 20};
  int e3 [8] = '{55, 47, 39, 32, 24, 16, 8, 0};
  int e6 [3] = '{26, 23, 19};

  dist_smoother #(.DW(6), .LOG2N(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dist_in       (dist_in),
    .dist_valid    (dist_valid),
    .clear         (clear),
    .dist_out      (dist_out),
    .dist_out_valid(dist_out_valid),
    .win_full      (win_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic cyc(input logic v, input logic [5:0] d, input logic c);
    dist_valid = v;
    dist_in    = d;
    clear      = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; dist_valid = 1'b0; dist_in = '0; clear = 1'b0;
    #12;
    chk("reset_out",   dist_out, 0);
    chk("reset_valid", dist_out_valid, 0);
    chk("reset_full",  win_full, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: fill with 20s
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 6'd20, 1'b0);
      chk("fill20_valid", dist_out_valid, 0);
      chk("fill20_full",  win_full, 0);
    end
    cyc(1'b1, 6'd20, 1'b0);
    chk("full20_out",   dist_out, 20);
    chk("full20_valid", dist_out_valid, 1);
    chk("full20_full",  win_full, 1);
    cyc(1'b0, 6'd0, 1'b0);
    chk("idle_valid", dist_out_valid, 0);
    chk("idle_out",   dist_out, 20);

    // 2: ramp to 40, back-to-back strobes
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 6'd40, 1'b0);
      chk("ramp40_out",   dist_out, 8'(e2[i]));
      chk("ramp40_valid", dist_out_valid, 1);
    end

    // 4: five strobes, then clear with a simultaneous strobe
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 6'd8, 1'b0);
      chk("pre_clear_out", dist_out, 8'(e4[i]));
    end
    cyc(1'b1, 6'd50, 1'b1);
    chk("clear_out",   dist_out, 20);
    chk("clear_valid", dist_out_valid, 0);
    chk("clear_full",  win_full, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 6'd63, 1'b0);
      chk("refill_valid", dist_out_valid, 0);
      chk("refill_out",   dist_out, 20);
      chk("refill_full",  win_full, 0);
    end
    cyc(1'b1, 6'd63, 1'b0);
    chk("max_out",   dist_out, 63);
    chk("max_valid", dist_out_valid, 1);
    chk("max_full",  win_full, 1);

    // 3: zeros into a window of 63s
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 6'd0, 1'b0);
`ifdef DIST_ZERO_REJECT_EN
      chk("zero_rej_valid", dist_out_valid, 0);
      chk("zero_rej_out",   dist_out, 63);
`else
      chk("decay_out",   dist_out, 8'(e3[i]));
      chk("decay_valid", dist_out_valid, 1);
`endif
      chk("decay_full", win_full, 1);
    end

    // 5: asynchronous reset in RUN, between edges
    cyc(1'b1, 6'd63, 1'b0);
    chk("pre_rst_valid", dist_out_valid, 1);
    dist_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out",   dist_out, 0);
    chk("arst_valid", dist_out_valid, 0);
    chk("arst_full",  win_full, 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 6'd30, 1'b0);
      chk("post_rst_valid", dist_out_valid, 0);
    end
    cyc(1'b1, 6'd30, 1'b0);
    chk("full30_out",   dist_out, 30);
    chk("full30_valid", dist_out_valid, 1);

    // 6: zero samples into a window of 30s
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 6'd0, 1'b0);
`ifdef DIST_ZERO_REJECT_EN
      chk("z30_valid", dist_out_valid, 0);
      chk("z30_out",   dist_out, 30);
`else
      chk("z30_valid", dist_out_valid, 1);
      chk("z30_out",   dist_out, 8'(e6[i]));
`endif
    end
    cyc(1'b1, 6'd38, 1'b0);
    chk("s38_valid", dist_out_valid, 1);
`ifdef DIST_ZERO_REJECT_EN
    chk("s38_out", dist_out, 31);
`else
    chk("s38_out", dist_out, 20);
`endif
    cyc(1'b0, 6'd0, 1'b0);
    chk("end_idle_valid", dist_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
